// File: rtl/param_display_reader_pkg.sv
// rtl/param_display_reader_pkg.sv - shared constants and seven-segment encoder for the parameter display reader
package param_display_reader_pkg;

  // FSM state encoding
  localparam logic [1:0] PDR_IDLE   = 2'd0;
  localparam logic [1:0] PDR_REQ    = 2'd1;
  localparam logic [1:0] PDR_CONV   = 2'd2;
  localparam logic [1:0] PDR_UPDATE = 2'd3;

  localparam int DISP_REFRESH_CNT = 2_500_000;
  localparam int DISP_ACK_TIMEOUT = 16;

  // Active-low segment codes, bit order g f e d c b a
  localparam logic [6:0] SEVSEG_SEG_0     = 7'b1000000;
  localparam logic [6:0] SEVSEG_SEG_1     = 7'b1111001;
  localparam logic [6:0] SEVSEG_SEG_2     = 7'b0100100;
  localparam logic [6:0] SEVSEG_SEG_3     = 7'b0110000;
  localparam logic [6:0] SEVSEG_SEG_4     = 7'b0011001;
  localparam logic [6:0] SEVSEG_SEG_5     = 7'b0010010;
  localparam logic [6:0] SEVSEG_SEG_6     = 7'b0000010;
  localparam logic [6:0] SEVSEG_SEG_7     = 7'b1111000;
  localparam logic [6:0] SEVSEG_SEG_8     = 7'b0000000;
  localparam logic [6:0] SEVSEG_SEG_9     = 7'b0010000;
  localparam logic [6:0] SEVSEG_SEG_A     = 7'b0001000;
  localparam logic [6:0] SEVSEG_SEG_B     = 7'b0000011;
  localparam logic [6:0] SEVSEG_SEG_C     = 7'b1000110;
  localparam logic [6:0] SEVSEG_SEG_D     = 7'b0100001;
  localparam logic [6:0] SEVSEG_SEG_E     = 7'b0000110;
  localparam logic [6:0] SEVSEG_SEG_F     = 7'b0001110;
  localparam logic [6:0] SEVSEG_SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEVSEG_SEG_LINE  = 7'b0111111;

  localparam logic [4:0] SEVSEG_BLANK_INDEX = 5'd16;
  localparam logic [4:0] SEVSEG_LINE_INDEX  = 5'd17;

  // Digit index 0..15 to glyph; 16 blanks the digit, anything else shows a dash
  function automatic logic [6:0] sevseg_encode(input logic [4:0] idx);
    case (idx)
      5'd0:    return SEVSEG_SEG_0;
      5'd1:    return SEVSEG_SEG_1;
      5'd2:    return SEVSEG_SEG_2;
      5'd3:    return SEVSEG_SEG_3;
      5'd4:    return SEVSEG_SEG_4;
      5'd5:    return SEVSEG_SEG_5;
      5'd6:    return SEVSEG_SEG_6;
      5'd7:    return SEVSEG_SEG_7;
      5'd8:    return SEVSEG_SEG_8;
      5'd9:    return SEVSEG_SEG_9;
      5'd10:   return SEVSEG_SEG_A;
      5'd11:   return SEVSEG_SEG_B;
      5'd12:   return SEVSEG_SEG_C;
      5'd13:   return SEVSEG_SEG_D;
      5'd14:   return SEVSEG_SEG_E;
      5'd15:   return SEVSEG_SEG_F;
      5'd16:   return SEVSEG_SEG_BLANK;
      default: return SEVSEG_SEG_LINE;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to three-digit BCD converter
module bin2bcd_seq
  import param_display_reader_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] din,
  output logic         done,
  output logic [11:0]  bcd
);

  localparam int CW = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST = CW'(W - 1);

  logic [11+W:0] sr;
  logic [11+W:0] adj;
  logic [CW-1:0] cnt;
  logic          active;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift
  always_comb begin
    adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (adj[W+4*i +: 4] >= 4'd5) begin
        adj[W+4*i +: 4] = adj[W+4*i +: 4] + 4'd3;
      end
    end
  end

  // Load on start, then one adjust-and-shift per cycle for W cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr     <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (start) begin
      sr     <= {12'd0, din};
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      sr  <= adj << 1;
      cnt <= cnt + 1'b1;
      if (cnt == LAST) begin
        active <= 1'b0;
      end
    end
  end

  assign done = active && (cnt == LAST);
  assign bcd  = sr[11+W:W];

endmodule

// File: rtl/param_display_reader.sv
// rtl/param_display_reader.sv - fetches the selected parameter and shows fx, param and decimal value on six displays
module param_display_reader
  import param_display_reader_pkg::*;
#(
  parameter int FX_COUNT    = 16,
  parameter int PARAM_COUNT = 8,
  parameter int PARAM_W     = 8,
  parameter int REFRESH_CNT = DISP_REFRESH_CNT,
  parameter int ACK_TIMEOUT = DISP_ACK_TIMEOUT
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [$clog2(FX_COUNT)-1:0]    fx_sel,
  input  logic [$clog2(PARAM_COUNT)-1:0] param_sel,
  output logic                           rd_req,
  output logic [$clog2(FX_COUNT)-1:0]    rd_fx,
  output logic [$clog2(PARAM_COUNT)-1:0] rd_param,
  input  logic                           rd_ack,
  input  logic [PARAM_W-1:0]             rd_data,
  output logic [6:0]                     hex5,
  output logic [6:0]                     hex4,
  output logic [6:0]                     hex3,
  output logic [6:0]                     hex2,
  output logic [6:0]                     hex1,
  output logic [6:0]                     hex0,
  output logic                           busy
);

  localparam int FXW = $clog2(FX_COUNT);
  localparam int PW  = $clog2(PARAM_COUNT);
  localparam int RW  = $clog2(REFRESH_CNT);
  localparam int TW  = $clog2(ACK_TIMEOUT);
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_CNT - 1);
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);

  logic [1:0]     state;
  logic [FXW-1:0] fx_q;
  logic [PW-1:0]  param_q;
  logic [RW-1:0]  ref_cnt;
  logic [TW-1:0]  ack_cnt;
  logic           pending;
  logic           fault;
  logic           sel_changed;
  logic           refresh_hit;
  logic           start_read;
  logic           conv_start;
  logic           conv_done;
  logic [11:0]    bcd;
  logic [6:0]     d2_code;
  logic [6:0]     d1_code;
  logic [6:0]     d0_code;

  assign sel_changed = (fx_sel != fx_q) || (param_sel != param_q);
  assign refresh_hit = (ref_cnt == REF_LAST);
  assign start_read  = (state == PDR_IDLE) && pending;
  assign conv_start  = (state == PDR_REQ) && rd_ack;
  assign rd_req      = (state == PDR_REQ);
  assign busy        = (state != PDR_IDLE);

  // Previous-cycle copy of the selection; tracks through reset so release sees no change
  always_ff @(posedge clk) begin
    fx_q    <= fx_sel;
    param_q <= param_sel;
  end

  // Free-running refresh timer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ref_cnt <= '0;
    end else if (refresh_hit) begin
      ref_cnt <= '0;
    end else begin
      ref_cnt <= ref_cnt + 1'b1;
    end
  end

  // Read request latch: set by selection change or refresh, cleared when IDLE launches a read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending <= 1'b1;
    end else if (sel_changed || refresh_hit) begin
      pending <= 1'b1;
    end else if (start_read) begin
      pending <= 1'b0;
    end
  end

  bin2bcd_seq #(.W(PARAM_W)) u_bin2bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (conv_start),
    .din   (rd_data),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Value digits with leading-zero blanking; the ones digit always shows
  always_comb begin
    d2_code = sevseg_encode({1'b0, bcd[11:8]});
    d1_code = sevseg_encode({1'b0, bcd[7:4]});
    d0_code = sevseg_encode({1'b0, bcd[3:0]});
    if (bcd[11:8] == 4'd0) begin
      d2_code = sevseg_encode(SEVSEG_BLANK_INDEX);
      if (bcd[7:4] == 4'd0) begin
        d1_code = sevseg_encode(SEVSEG_BLANK_INDEX);
      end
    end
  end

  // Read/convert/display sequencer; displays only change in UPDATE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= PDR_IDLE;
      rd_fx    <= '0;
      rd_param <= '0;
      ack_cnt  <= '0;
      fault    <= 1'b0;
      hex5     <= SEVSEG_SEG_LINE;
      hex4     <= SEVSEG_SEG_LINE;
      hex3     <= SEVSEG_SEG_LINE;
      hex2     <= SEVSEG_SEG_LINE;
      hex1     <= SEVSEG_SEG_LINE;
      hex0     <= SEVSEG_SEG_LINE;
    end else begin
      case (state)
        PDR_IDLE: begin
          if (pending) begin
            rd_fx    <= fx_sel;
            rd_param <= param_sel;
            ack_cnt  <= '0;
            fault    <= 1'b0;
            state    <= PDR_REQ;
          end
        end
        PDR_REQ: begin
          if (rd_ack) begin
            state <= PDR_CONV;
          end else if (ack_cnt == ACK_LAST) begin
            fault <= 1'b1;
            state <= PDR_UPDATE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        PDR_CONV: begin
          if (conv_done) begin
            state <= PDR_UPDATE;
          end
        end
        default: begin
          hex5 <= sevseg_encode(5'(rd_fx));
          hex4 <= SEVSEG_SEG_LINE;
          hex3 <= sevseg_encode(5'(rd_param));
          if (fault) begin
            hex2 <= sevseg_encode(SEVSEG_LINE_INDEX);
            hex1 <= sevseg_encode(SEVSEG_LINE_INDEX);
            hex0 <= sevseg_encode(SEVSEG_LINE_INDEX);
          end else begin
            hex2 <= d2_code;
            hex1 <= d1_code;
            hex0 <= d0_code;
          end
          state <= PDR_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_param_display_reader.sv
// tb/tb_param_display_reader.sv - self-checking bench for param_display_reader
module tb_param_display_reader;

  localparam int REF = 1000;
  localparam logic [6:0] LINE  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] fx_sel;
  logic [2:0] param_sel;
  logic       rd_req;
  logic [3:0] rd_fx;
  logic [2:0] rd_param;
  logic       rd_ack;
  logic [7:0] rd_data;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int req_cycles = 0;
  int ack_delay = 0;
  logic bank_en = 1'b1;
  logic [7:0] mem [0:15][0:7];
  logic [6:0] glyph [0:15];

  param_display_reader #(.REFRESH_CNT(REF)) dut (
    .clk(clk), .rst_n(rst_n), .fx_sel(fx_sel), .param_sel(param_sel),
    .rd_req(rd_req), .rd_fx(rd_fx), .rd_param(rd_param),
    .rd_ack(rd_ack), .rd_data(rd_data),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Parameter bank model: answers after ack_delay REQ cycles when enabled
  always @(posedge clk) req_cycles <= rd_req ? req_cycles + 1 : 0;
  assign rd_ack  = rd_req && bank_en && (req_cycles == ack_delay);
  assign rd_data = mem[rd_fx][rd_param];

  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_display(input string tag, input int f, input int p, input int v, input bit flt);
    int h, t, o;
    h = v / 100; t = (v / 10) % 10; o = v % 10;
    check({tag, ".hex5"}, hex5, glyph[f]);
    check({tag, ".hex4"}, hex4, LINE);
    check({tag, ".hex3"}, hex3, glyph[p]);
    check({tag, ".hex2"}, hex2, flt ? LINE : (h == 0 ? BLANK : glyph[h]));
    check({tag, ".hex1"}, hex1, flt ? LINE : ((h == 0 && t == 0) ? BLANK : glyph[t]));
    check({tag, ".hex0"}, hex0, flt ? LINE : glyph[o]);
  endtask

  task automatic check_all_line(input string tag);
    check({tag, ".hex5"}, hex5, LINE);
    check({tag, ".hex4"}, hex4, LINE);
    check({tag, ".hex3"}, hex3, LINE);
    check({tag, ".hex2"}, hex2, LINE);
    check({tag, ".hex1"}, hex1, LINE);
    check({tag, ".hex0"}, hex0, LINE);
    check({tag, ".rd_req"}, rd_req, 0);
    check({tag, ".busy"}, busy, 0);
  endtask

  task automatic settle(input string tag);
    int idle = 0;
    int n = 0;
    while (idle < 3 && n < 400) begin
      @(negedge clk);
      n++;
      idle = busy ? 0 : idle + 1;
    end
    check({tag, ".settled"}, idle >= 3, 1);
  endtask

  task automatic align();
    int n = 0;
    while ((cyc % REF) != 100 && n < 3 * REF) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (!rd_req && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, ".req_seen"}, rd_req, 1);
  endtask

  task automatic do_read(input string tag, input int f, input int p, input int v, input int d);
    align();
    mem[f][p] = 8'(v);
    ack_delay = d;
    @(negedge clk);
    fx_sel = 4'(f);
    param_sel = 3'(p);
    settle(tag);
    check_display(tag, f, p, v, 1'b0);
  endtask

  initial begin
    int f, p, n, first, second;
    logic prev;
    glyph[0] = 7'b1000000; glyph[1] = 7'b1111001; glyph[2] = 7'b0100100; glyph[3] = 7'b0110000;
    glyph[4] = 7'b0011001; glyph[5] = 7'b0010010; glyph[6] = 7'b0000010; glyph[7] = 7'b1111000;
    glyph[8] = 7'b0000000; glyph[9] = 7'b0010000; glyph[10] = 7'b0001000; glyph[11] = 7'b0000011;
    glyph[12] = 7'b1000110; glyph[13] = 7'b0100001; glyph[14] = 7'b0000110; glyph[15] = 7'b0001110;
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 8; j++)
        mem[i][j] = 8'($urandom_range(0, 255));
    mem[0][0] = 8'd9;

    // Reset state
    rst_n = 1'b0; fx_sel = 4'd0; param_sel = 3'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_line("reset");
    rst_n = 1'b1;
    settle("boot");
    check_display("boot", 0, 0, 9, 1'b0);

    // Selection change latency with an immediate ack
    align();
    mem[2][1] = 8'd32;
    ack_delay = 0;
    @(negedge clk);
    fx_sel = 4'd2; param_sel = 3'd1;
    n = 0;
    while (n < 30) begin
      @(negedge clk);
      n++;
      if (hex0 == glyph[2] && hex5 == glyph[2]) break;
    end
    check("latency", n, 12);
    check_display("fx2p1v32", 2, 1, 32, 1'b0);

    // Extremes on fx 15
    do_read("v255", 15, 2, 255, 3);
    do_read("v0", 15, 5, 0, 0);

    // Randomised reads with varying ack delay
    for (int it = 0; it < 16; it++) begin
      f = int'($urandom_range(0, 15));
      p = int'($urandom_range(0, 7));
      while (f == int'(fx_sel) && p == int'(param_sel)) p = int'($urandom_range(0, 7));
      do_read($sformatf("rand%0d", it), f, p, int'($urandom_range(0, 255)), int'($urandom_range(0, 12)));
    end

    // Bank never acknowledges
    align();
    bank_en = 1'b0;
    @(negedge clk);
    fx_sel = 4'd7; param_sel = 3'd6;
    wait_req("timeout");
    n = 0;
    while (rd_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("timeout.req_cycles", n, 16);
    settle("timeout");
    check_display("timeout", 7, 6, 0, 1'b1);
    bank_en = 1'b1;

    // Selection change during conversion shows the old pair, then re-reads
    do_read("pre_conv", 3, 5, 60, 0);
    align();
    mem[3][0] = 8'd123; mem[3][3] = 8'd45; ack_delay = 0;
    @(negedge clk);
    param_sel = 3'd0;
    wait_req("conv_chg");
    @(negedge clk);
    check("conv_chg.in_conv", busy && !rd_req, 1);
    param_sel = 3'd3;
    n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_display("conv_chg.old", 3, 0, 123, 1'b0);
    wait_req("conv_chg2");
    check("conv_chg2.rd_param", rd_param, 3);
    check("conv_chg2.rd_fx", rd_fx, 3);
    settle("conv_chg2");
    check_display("conv_chg.new", 3, 3, 45, 1'b0);

    // Periodic refresh with a stable selection
    align();
    prev = rd_req; first = -1; second = -1; n = 0;
    while (second < 0 && n < 2500) begin
      @(negedge clk);
      n++;
      if (rd_req && !prev) begin
        if (first < 0) first = cyc; else second = cyc;
      end
      prev = rd_req;
    end
    check("refresh.interval", second - first, REF);

    // Reset during conversion
    align();
    mem[4][4] = 8'd200;
    @(negedge clk);
    fx_sel = 4'd4; param_sel = 3'd4;
    wait_req("rst_conv");
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_line("rst_conv");
    rst_n = 1'b1;
    wait_req("rst_conv.fresh");
    check("rst_conv.rd_param", rd_param, 4);
    settle("rst_conv");
    check_display("rst_conv", 4, 4, 200, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
